// File: rtl/game_core_if.sv
// Reel/scoring bus for game_core: controller inputs and reel/score outputs.
// dbg_state mirrors the internal FSM (0=IDLE, 1=SPIN, 2=EVAL).
interface game_core_if;
   logic       start_p;
   logic [3:0] cur_state;
   logic [1:0] refresh;
   logic       ref_sign;
   logic [3:0] randNum;
   logic [3:0] result;
   logic [3:0] number1;
   logic [3:0] number2;
   logic [3:0] number3;
   logic       score_sign;
   logic       turn_p;
   logic [1:0] dbg_state;

   // Inputs are sampled on the rising edge; pulses are single-cycle, no backpressure.
   modport slave (
      input  start_p, cur_state, refresh, ref_sign, randNum,
      output result, number1, number2, number3, score_sign, turn_p, dbg_state
   );

   modport master (
      output start_p, cur_state, refresh, ref_sign, randNum,
      input  result, number1, number2, number3, score_sign, turn_p, dbg_state
   );
endinterface

// File: rtl/game_core.sv
// Reel/scoring core of the one-arm-bandit: spins three decimal reels and scores them.
// Optional macro SEVEN_JACKPOT_EN: a triple 7 pays PAY_JACKPOT instead of PAY_TRIPLE.
module game_core #(
   parameter logic [3:0] PLAY_STATE  = 4'b0001,
   parameter logic [3:0] PAY_PAIR    = 4'd2,
   parameter logic [3:0] PAY_TRIPLE  = 4'd8,
   parameter logic [3:0] PAY_JACKPOT = 4'd15
) (
   input logic        clk,
   input logic        rst_n,
   game_core_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPIN = 2'd1,
      EVAL = 2'd2
   } state_t;

   state_t     state_q;
   logic [1:0] ptr_q;
   logic [3:0] n1_q, n2_q, n3_q;
   logic [3:0] result_q;
   logic       turn_q;
   logic       score_q;

   logic       play;
   logic [3:0] digit;
   logic [3:0] result_d;

   assign play = (bus.cur_state == PLAY_STATE);

   always_comb begin
      digit = bus.randNum;
      if (bus.randNum > 4'd9) digit = bus.randNum - 4'd10;
   end

   always_comb begin
      result_d = 4'd0;
      if (n1_q == n2_q && n2_q == n3_q) begin
`ifdef SEVEN_JACKPOT_EN
         result_d = (n1_q == 4'd7) ? PAY_JACKPOT : PAY_TRIPLE;
`else
         result_d = PAY_TRIPLE;
`endif
      end else if (n1_q == n2_q || n2_q == n3_q || n1_q == n3_q) begin
         result_d = PAY_PAIR;
      end
   end

   // rst_n is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd1;
         n1_q     <= 4'd0;
         n2_q     <= 4'd0;
         n3_q     <= 4'd0;
         result_q <= 4'd0;
         turn_q   <= 1'b0;
         score_q  <= 1'b0;
      end else begin
         turn_q  <= 1'b0;
         score_q <= 1'b0;
         if (!play) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start_p) begin
                     state_q <= SPIN;
                     ptr_q   <= 2'd1;
                  end
               end
               SPIN: begin
                  // Score on the same edge refresh==3 is seen so outputs show during EVAL.
                  if (bus.refresh == 2'd3) begin
                     state_q  <= EVAL;
                     result_q <= result_d;
                     turn_q   <= 1'b1;
                     score_q  <= (result_d != 4'd0);
                  end else if (bus.ref_sign) begin
                     if (bus.refresh < ptr_q) begin
                        case (ptr_q)
                           2'd1:    n1_q <= digit;
                           2'd2:    n2_q <= digit;
                           default: n3_q <= digit;
                        endcase
                     end
                     ptr_q <= (ptr_q == 2'd3) ? 2'd1 : ptr_q + 2'd1;
                  end
               end
               EVAL:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.result     = result_q;
   assign bus.number1    = n1_q;
   assign bus.number2    = n2_q;
   assign bus.number3    = n3_q;
   assign bus.score_sign = score_q;
   assign bus.turn_p     = turn_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_game_core.sv
// Self-checking bench for game_core: table-driven turns, randomized turns against
// a reel model, and hand-written sequences for hold/abort/reset corners.
module tb_game_core;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   game_core_if bus();

   game_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;
   logic [3:0] exp_q[$];
   int m_reel[1:3];
   logic [3:0] tick_raw[$];
   logic [1:0] tick_ref[$];

   typedef struct {
      logic [3:0] r1, r2, r3;
      logic [3:0] e1, e2, e3;
      logic [3:0] eres;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] model_score(input int a, input int b, input int c);
      int eq;
      eq = int'(a == b) + int'(b == c) + int'(a == c);
      if (eq == 3) begin
`ifdef SEVEN_JACKPOT_EN
         if (a == 7) return 4'd15;
`endif
         return 4'd8;
      end
      if (eq == 1) return 4'd2;
      return 4'd0;
   endfunction

   task automatic do_tick(input logic [3:0] raw, input logic [1:0] r);
      bus.refresh  = r;
      bus.randNum  = raw;
      bus.ref_sign = 1'b1;
      step();
      bus.ref_sign = 1'b0;
      step();
   endtask

   task automatic start_pulse();
      bus.start_p = 1'b1;
      step();
      bus.start_p = 1'b0;
   endtask

   // Plays one full turn from tick_raw/tick_ref and checks it against the reel model.
   task automatic run_turn(input string tag);
      logic [3:0] e;
      int idx;
      start_pulse();
      check({tag, "_spin_state"}, bus.dbg_state, 1);
      for (int i = 0; i < tick_raw.size(); i++) begin
         do_tick(tick_raw[i], tick_ref[i]);
         idx = (i % 3) + 1;
         if (int'(tick_ref[i]) < idx) m_reel[idx] = int'(tick_raw[i]) % 10;
      end
      check({tag, "_n1"}, bus.number1, m_reel[1]);
      check({tag, "_n2"}, bus.number2, m_reel[2]);
      check({tag, "_n3"}, bus.number3, m_reel[3]);
      exp_q.push_back(model_score(m_reel[1], m_reel[2], m_reel[3]));
      bus.refresh = 2'd3;
      step();
      e = exp_q.pop_front();
      check({tag, "_turn_p"}, bus.turn_p, 1);
      check({tag, "_result"}, bus.result, e);
      check({tag, "_score_sign"}, bus.score_sign, (e != 4'd0));
      step();
      check({tag, "_turn_p_end"}, {bus.turn_p, bus.score_sign}, 0);
      check({tag, "_idle"}, bus.dbg_state, 0);
      bus.refresh = 2'd0;
   endtask

   initial begin
      logic pulse_seen;
      int nt;
      logic [1:0] r;

      bus.start_p   = 1'b0;
      bus.cur_state = 4'b0001;
      bus.refresh   = 2'd0;
      bus.ref_sign  = 1'b0;
      bus.randNum   = 4'd0;
      for (int k = 1; k <= 3; k++) m_reel[k] = 0;

      // Reset then idle
      #100;
      check("rst_outputs", {bus.result, bus.number1, bus.number2, bus.number3}, 0);
      check("rst_pulses", {bus.turn_p, bus.score_sign}, 0);
      check("rst_state", bus.dbg_state, 0);
      @(negedge clk);
      rst_n = 1'b0;
      pulse_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus.turn_p || bus.score_sign) pulse_seen = 1'b1;
      end
      check("idle_no_pulse", pulse_seen, 0);
      check("idle_outputs", {bus.result, bus.number1, bus.number2, bus.number3}, 0);

      tbl[0] = '{4'd5,  4'd5,  4'd5, 4'd5, 4'd5, 4'd5, 4'd8};
      tbl[1] = '{4'd12, 4'd2,  4'd9, 4'd2, 4'd2, 4'd9, 4'd2};
      tbl[2] = '{4'd1,  4'd4,  4'd6, 4'd1, 4'd4, 4'd6, 4'd0};
      tbl[3] = '{4'd15, 4'd5,  4'd0, 4'd5, 4'd5, 4'd0, 4'd2};
      tbl[4] = '{4'd10, 4'd0,  4'd3, 4'd0, 4'd0, 4'd3, 4'd2};
`ifdef SEVEN_JACKPOT_EN
      tbl[5] = '{4'd7,  4'd7,  4'd7, 4'd7, 4'd7, 4'd7, 4'd15};
`else
      tbl[5] = '{4'd7,  4'd7,  4'd7, 4'd7, 4'd7, 4'd7, 4'd8};
`endif
      tbl[6] = '{4'd9,  4'd13, 4'd3, 4'd9, 4'd3, 4'd3, 4'd2};
      tbl[7] = '{4'd11, 4'd14, 4'd2, 4'd1, 4'd4, 4'd2, 4'd0};

      foreach (tbl[v]) begin
         tick_raw = '{tbl[v].r1, tbl[v].r2, tbl[v].r3};
         tick_ref = '{2'd0, 2'd0, 2'd0};
         run_turn($sformatf("tbl%0d", v));
         check($sformatf("tbl%0d_digits", v), {bus.number1, bus.number2, bus.number3},
               {tbl[v].e1, tbl[v].e2, tbl[v].e3});
         check($sformatf("tbl%0d_held_result", v), bus.result, tbl[v].eres);
      end

      // Six ticks with refresh stepped 1,2 between stops
      tick_raw = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
      tick_ref = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
      run_turn("six_tick");

      // Stopped reel holds while others keep rolling
      tick_raw = '{4'd3, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
      tick_ref = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
      run_turn("hold");
      check("hold_n1_const", bus.number1, 3);
      check("hold_result", bus.result, 2);

      // refresh==3 together with ref_sign: no reel update
      start_pulse();
      do_tick(4'd1, 2'd0);
      do_tick(4'd2, 2'd0);
      do_tick(4'd3, 2'd0);
      bus.refresh  = 2'd3;
      bus.randNum  = 4'd9;
      bus.ref_sign = 1'b1;
      step();
      bus.ref_sign = 1'b0;
      check("same_cycle_digits", {bus.number1, bus.number2, bus.number3}, 12'h123);
      check("same_cycle_turn", {bus.turn_p, bus.score_sign, bus.result}, 6'b10_0000);
      step();
      bus.refresh = 2'd0;

      // Abort mid-spin
      start_pulse();
      do_tick(4'd4, 2'd0);
      bus.cur_state = 4'b0010;
      step();
      check("abort_state", bus.dbg_state, 0);
      do_tick(4'd6, 2'd0);
      do_tick(4'd6, 2'd0);
      bus.refresh = 2'd3;
      pulse_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (bus.turn_p || bus.score_sign) pulse_seen = 1'b1;
      end
      check("abort_no_turn", pulse_seen, 0);
      check("abort_digits", {bus.number1, bus.number2, bus.number3}, 12'h423);
      check("abort_result_held", bus.result, 0);
      bus.refresh = 2'd0;
      start_pulse();
      check("start_outside_play", bus.dbg_state, 0);
      bus.cur_state = 4'b0001;
      step();

      // start_p during SPIN does not restart the reel pointer
      start_pulse();
      do_tick(4'd1, 2'd0);
      start_pulse();
      do_tick(4'd5, 2'd0);
      check("spin_restart_ignored", {bus.number1, bus.number2}, 8'h15);
      bus.refresh = 2'd3;
      step();
      check("spin_restart_turn", bus.turn_p, 1);
      step();
      bus.refresh = 2'd0;
      m_reel[1] = 1;
      m_reel[2] = 5;
      m_reel[3] = 3;

      // Randomized turns against the reel model
      for (int t = 0; t < 30; t++) begin
         nt = $urandom_range(3, 12);
         r = 2'd0;
         tick_raw.delete();
         tick_ref.delete();
         for (int i = 0; i < nt; i++) begin
            if ($urandom_range(0, 3) == 0 && r < 2'd2) r = r + 2'd1;
            tick_ref.push_back(r);
            if ($urandom_range(0, 1) == 0)
               tick_raw.push_back(4'($urandom_range(0, 15)));
            else
               tick_raw.push_back(4'($urandom_range(6, 8)));
         end
         run_turn($sformatf("rnd%0d", t));
      end

      // Asynchronous reset mid-spin
      start_pulse();
      do_tick(4'd7, 2'd0);
      #2;
      rst_n = 1'b1;
      #1;
      check("async_rst_outputs", {bus.result, bus.number1, bus.number2, bus.number3}, 0);
      check("async_rst_state", bus.dbg_state, 0);
      step();
      rst_n = 1'b0;
      step();
      check("post_rst_idle", {bus.turn_p, bus.score_sign, bus.dbg_state}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
